vga_plot_arbiter: RTL and testbench
===================================

Name: vga_plot_arbiter

Overview:
- Shares the single pixel-write port of vga_adapter (x, y, colour, plot) among several pixel producers.
- Requesters, by index: 0 = screen-clear/init sequencer, 1 = axis/grid drawer, 2 = function plotter.
- Grants one requester at a time, forwards its pixel writes through one register stage, and forces hand-over on long bursts so no producer starves.
- Replaces ad-hoc muxing between init and function pixel streams in front of the VGA adapter.

Parameters:
- N, 3, number of requesters (≥2); index 0 is the priority requester.
- X_W, 9, x coordinate width (320 columns).
- Y_W, 8, y coordinate width (240 rows).
- COL_W, 6, colour width (2 bits per channel).
- MAX_BURST, 64, max pixels per grant before forced release when others wait; 0 disables.

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous active-low reset (KEY[3]); 0 = reset
- req  in  N  request bus; bit k held high while requester k wants the port
- plot_in  in  N  pixel-valid per requester
- last_in  in  N  final-pixel marker, qualified by plot_in
- x_in  in  N*X_W  packed x; requester k at [k*X_W +: X_W]
- y_in  in  N*Y_W  packed y, same packing
- col_in  in  N*COL_W  packed colour, same packing
- gnt  out  N  one-hot grant, registered
- x_out  out  X_W  to vga_adapter x
- y_out  out  Y_W  to vga_adapter y
- col_out  out  COL_W  to vga_adapter colour
- plot_out  out  1  to vga_adapter plot
- busy  out  1  high while any grant is held
- dropped  out  1  one-cycle pulse when a non-owner asserts plot_in

Behaviour:
- Reset (async, any time, including mid-burst):
  - gnt=0, x_out=0, y_out=0, col_out=0, plot_out=0, busy=0, dropped=0.
  - State IDLE, burst count 0, round-robin pointer = 1.
  - Any in-flight pixel is lost.
- States: IDLE, OWN.
- IDLE:
  - If any req bit is set, the winner's gnt bit rises on the next edge and state becomes OWN. Grant latency is 1 cycle.
  - Winner: req[0] if set. Otherwise the first set bit among 1..N-1, scanning from the pointer upward with wrap back to 1.
  - After granting k≥1, pointer = k+1, wrapping N→1. Granting 0 leaves the pointer unchanged.
- OWN, owner k:
  - When plot_in[k]=1, x/y/col of slice k are registered to the outputs and plot_out=1 on the next cycle. Pixel latency is 1 cycle.
  - plot_out=0 on every other cycle; x/y/col_out hold their last values.
  - Release conditions, each evaluated per cycle:
    - (a) plot_in[k] & last_in[k];
    - (b) req[k]=0;
    - (c) MAX_BURST≠0, the burst count reaches MAX_BURST with this plot, and some req[j], j≠k, is set.
  - On release, gnt clears on the next edge and state returns to IDLE. A pixel presented in the release cycle is still written.
  - After any release there is a mandatory one-cycle IDLE gap, so the minimum back-to-back grant spacing is 2 cycles.
  - Burst count: cleared on grant, incremented on each accepted owner pixel, saturating.
- Preemption: no mid-burst preemption by priority. req[0] only wins at the next arbitration, but is still subject to timeout rule (c) like any owner.
- Non-owner plot_in[j], j≠k, or any plot_in while IDLE:
  - The pixel is ignored.
  - dropped=1 for one cycle, registered.
  - Owner traffic in the same cycle proceeds normally.
- A requester that drops req and re-raises it in the same IDLE cycle simply re-arbitrates.
- busy = |gnt.
- Width rules:
  - Coordinates pass through unmodified; no clipping.
  - Out-of-range pixels are the producer's responsibility.

Test Plan:
- Single grant: reset released, req=3'b100 → gnt=3'b100 one cycle later. Plot (x=10, y=20, col=6'h3F) with last → plot_out=1 next cycle with x_out=10, y_out=20, col_out=3F; gnt=0 one cycle after.
- Priority: req=3'b111 in IDLE → gnt=3'b001. After release by last, with req=3'b110 still set → gnt=3'b010 after the 1-cycle gap, then 3'b100 after the next release.
- Round robin: req[1] and req[2] held high, each releasing after 1 pixel → grants alternate 010, 100, 010; req[0] raised mid-sequence wins the next arbitration.
- Burst timeout: MAX_BURST=4, owner 2 streams plot every cycle with no last, req[1]=1 → exactly 4 plot_out pulses, then gnt 100→000→010.
- Timeout with no contention: same as above but req[1]=0 → owner 2 keeps the grant past 4 pixels; 100 pixels are all forwarded.
- Drop/reset: owner 1 granted, requester 2 pulses plot_in → dropped=1 for 1 cycle and no plot_out for it. Then reset low mid-burst → all outputs 0 immediately (async). After reset release, pointer=1, verified by req=3'b110 → gnt=3'b010.

Source files
------------

// File: rtl/vga_plot_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_plot_arbiter_if
// Bundles the pixel producers' request/pixel bus and the arbitrated
// pixel-write port that feeds vga_adapter.
//
// Signals (producer side -> arbiter):
//   req      [N]        bit k held high while requester k wants the port
//   plot_in  [N]        pixel-valid per requester
//   last_in  [N]        final-pixel marker, qualified by plot_in
//   x_in     [N*X_W]    packed x, requester k at [k*X_W +: X_W]
//   y_in     [N*Y_W]    packed y, same packing
//   col_in   [N*COL_W]  packed colour, same packing
// Signals (arbiter -> producers / vga_adapter):
//   gnt      [N]        one-hot registered grant
//   x_out, y_out, col_out, plot_out   pixel write towards vga_adapter
//   busy                high while any grant is held
//   dropped             one-cycle pulse when a non-owner tried to plot
//
// Modports: master = producer side, slave = arbiter.
// ---------------------------------------------------------------------------
interface vga_plot_arbiter_if #(
    parameter int N     = 3,
    parameter int X_W   = 9,
    parameter int Y_W   = 8,
    parameter int COL_W = 6
);
    logic [N-1:0]       req;
    logic [N-1:0]       plot_in;
    logic [N-1:0]       last_in;
    logic [N*X_W-1:0]   x_in;
    logic [N*Y_W-1:0]   y_in;
    logic [N*COL_W-1:0] col_in;

    logic [N-1:0]       gnt;
    logic [X_W-1:0]     x_out;
    logic [Y_W-1:0]     y_out;
    logic [COL_W-1:0]   col_out;
    logic               plot_out;
    logic               busy;
    logic               dropped;

    modport master (
        output req, plot_in, last_in, x_in, y_in, col_in,
        input  gnt, x_out, y_out, col_out, plot_out, busy, dropped
    );

    modport slave (
        input  req, plot_in, last_in, x_in, y_in, col_in,
        output gnt, x_out, y_out, col_out, plot_out, busy, dropped
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// ---------------------------------------------------------------------------
// vga_plot_arbiter
// Shares the single pixel-write port of vga_adapter among N pixel producers
// (0 = screen-clear sequencer, 1 = axis/grid drawer, 2 = function plotter).
// One requester owns the port at a time; its pixels are forwarded through a
// single register stage. Requester 0 has priority at arbitration time, the
// rest are served round-robin, and long bursts are cut after MAX_BURST pixels
// when someone else is waiting (MAX_BURST = 0 disables the cut).
//
// Ports:
//   clk    system clock (CLOCK_50)
//   reset  asynchronous active-low reset (0 = reset)
//   bus    vga_plot_arbiter_if.slave, see the interface file for signals
//
// The interface instance must be built with the same N/X_W/Y_W/COL_W as
// this module.
// ---------------------------------------------------------------------------
module vga_plot_arbiter #(
    parameter int N         = 3,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int COL_W     = 6,
    parameter int MAX_BURST = 64
) (
    input logic               clk,
    input logic               reset,
    vga_plot_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(MAX_BURST + 2);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [N-1:0]       gnt_q, gnt_nxt;
    logic [IDX_W-1:0]   winner;
    logic               found;
    logic               owner_plot;
    logic               others_req;
    logic               burst_hit;
    logic               release_now;
    logic               drop_nxt;

    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [COL_W-1:0]   col_q;
    logic               plot_q;
    logic               drop_q;

    // Round-robin candidate: offset steps past the pointer through the
    // non-priority indices 1..N-1, wrapping back to 1 (index 0 is never
    // part of the rotation).
    function automatic logic [IDX_W-1:0] scan_idx(input logic [IDX_W-1:0] base,
                                                  input int offset);
        int v;
        v = int'(base) + offset;
        if (v >= N) v = v - (N - 1);
        return IDX_W'(v);
    endfunction

    // Winner of the next arbitration: requester 0 outright, otherwise the
    // first requester found scanning upward from the round-robin pointer.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        if (!bus.req[0]) begin
            for (int i = 0; i < N - 1; i++) begin
                if (!found && bus.req[scan_idx(ptr, i)]) begin
                    winner = scan_idx(ptr, i);
                    found  = 1'b1;
                end
            end
        end
    end

    // Next-state and next-register values. A release always goes through
    // IDLE, which is what produces the one-cycle gap between owners.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        gnt_nxt     = gnt_q;
        owner_plot  = 1'b0;
        others_req  = 1'b0;
        burst_hit   = 1'b0;
        release_now = 1'b0;
        drop_nxt    = 1'b0;

        case (state)
            IDLE: begin
                drop_nxt = |bus.plot_in;
                cnt_nxt  = '0;
                if (|bus.req) begin
                    state_nxt = OWN;
                    owner_nxt = winner;
                    gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << winner;
                    if (winner != '0) begin
                        ptr_nxt = (winner == IDX_W'(N - 1)) ? IDX_W'(1) : winner + IDX_W'(1);
                    end
                end
            end
            OWN: begin
                owner_plot = bus.plot_in[owner];
                drop_nxt   = |(bus.plot_in & ~gnt_q);
                others_req = |(bus.req & ~gnt_q);
                // The count saturates at MAX_BURST, so ">= MAX_BURST-1"
                // also covers an owner that ran past the limit while
                // nobody was waiting and then gets a competitor.
                burst_hit  = (MAX_BURST != 0) && owner_plot && (cnt >= BURST_LAST) && others_req;
                if (owner_plot && (cnt != CNT_MAX)) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                release_now = (owner_plot && bus.last_in[owner]) || !bus.req[owner] || burst_hit;
                if (release_now) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration bookkeeping and the single pixel register stage. The
    // coordinates hold their last value when no owner pixel is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q  <= '0;
            owner  <= '0;
            ptr    <= IDX_W'(1);
            cnt    <= '0;
            plot_q <= 1'b0;
            drop_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            col_q  <= '0;
        end else begin
            gnt_q  <= gnt_nxt;
            owner  <= owner_nxt;
            ptr    <= ptr_nxt;
            cnt    <= cnt_nxt;
            plot_q <= owner_plot;
            drop_q <= drop_nxt;
            if (owner_plot) begin
                x_q   <= bus.x_in[owner * X_W +: X_W];
                y_q   <= bus.y_in[owner * Y_W +: Y_W];
                col_q <= bus.col_in[owner * COL_W +: COL_W];
            end
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.busy     = |gnt_q;
    assign bus.x_out    = x_q;
    assign bus.y_out    = y_q;
    assign bus.col_out  = col_q;
    assign bus.plot_out = plot_q;
    assign bus.dropped  = drop_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_plot_arbiter
// Self-checking bench for vga_plot_arbiter (built with MAX_BURST = 4 so the
// burst cut is reachable quickly). A cycle-level behavioural model tracks
// the owner as an integer, the round-robin pointer and the burst length,
// and predicts every registered output; directed scenarios add fixed
// expectations on top of the model.
// ---------------------------------------------------------------------------
module tb_vga_plot_arbiter;

    localparam int N         = 3;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int COL_W     = 6;
    localparam int MAX_BURST = 4;
    localparam int OW        = N + X_W + Y_W + COL_W + 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    vga_plot_arbiter_if #(.N(N), .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W)) bus ();

    vga_plot_arbiter #(
        .N(N), .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Model state: owner (-1 = nobody), pointer, pixels in current burst.
    int               m_owner;
    int               m_ptr;
    int               m_burst;
    logic [X_W-1:0]   e_x;
    logic [Y_W-1:0]   e_y;
    logic [COL_W-1:0] e_col;
    logic             e_plot;
    logic             e_drop;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [OW-1:0] dut_outs();
        return {bus.gnt, bus.x_out, bus.y_out, bus.col_out, bus.plot_out, bus.busy, bus.dropped};
    endfunction

    function automatic logic [OW-1:0] exp_outs();
        logic [N-1:0] g;
        logic         b;
        g = '0;
        b = 1'b0;
        if (m_owner >= 0) begin
            g[m_owner] = 1'b1;
            b = 1'b1;
        end
        return {g, e_x, e_y, e_col, e_plot, b, e_drop};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 1;
        m_burst = 0;
        e_x     = '0;
        e_y     = '0;
        e_col   = '0;
        e_plot  = 1'b0;
        e_drop  = 1'b0;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] p, input logic [N-1:0] l);
        bus.req     = r;
        bus.plot_in = p;
        bus.last_in = l;
        for (int k = 0; k < N; k++) begin
            bus.x_in[k*X_W +: X_W]       = X_W'($urandom_range(0, 319));
            bus.y_in[k*Y_W +: Y_W]       = Y_W'($urandom_range(0, 239));
            bus.col_in[k*COL_W +: COL_W] = COL_W'($urandom);
        end
    endtask

    // Predicts the effect of the current inputs, advances one clock edge,
    // then leaves the caller 2 time units past the edge to sample.
    task automatic step();
        int               nown, nptr, nburst, k;
        logic             np, nd, others;
        logic [X_W-1:0]   nx;
        logic [Y_W-1:0]   ny;
        logic [COL_W-1:0] nc;
        nown = m_owner; nptr = m_ptr; nburst = m_burst;
        np = 1'b0; nd = 1'b0; others = 1'b0;
        nx = e_x; ny = e_y; nc = e_col;
        if (m_owner < 0) begin
            nd = |bus.plot_in;
            if (|bus.req) begin
                if (bus.req[0]) begin
                    nown = 0;
                end else begin
                    for (int i = 0; i < N - 1; i++) begin
                        k = (m_ptr - 1 + i) % (N - 1) + 1;
                        if (nown < 0 && bus.req[k]) nown = k;
                    end
                    nptr = nown % (N - 1) + 1;
                end
                nburst = 0;
            end
        end else begin
            k = m_owner;
            for (int j = 0; j < N; j++) begin
                if (j != k && bus.plot_in[j]) nd = 1'b1;
                if (j != k && bus.req[j])     others = 1'b1;
            end
            if (bus.plot_in[k]) begin
                np     = 1'b1;
                nx     = bus.x_in[k*X_W +: X_W];
                ny     = bus.y_in[k*Y_W +: Y_W];
                nc     = bus.col_in[k*COL_W +: COL_W];
                nburst = m_burst + 1;
            end
            if ((bus.plot_in[k] && bus.last_in[k]) || !bus.req[k] ||
                (MAX_BURST != 0 && bus.plot_in[k] && nburst >= MAX_BURST && others))
                nown = -1;
        end
        @(posedge clk);
        m_owner = nown; m_ptr = nptr; m_burst = nburst;
        e_plot = np; e_drop = nd; e_x = nx; e_y = ny; e_col = nc;
        #2;
    endtask

    task automatic quiesce();
        drive('0, '0, '0);
        step();
        step();
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        drive('0, '0, '0);
        #1;
        n_vec++;
        if (dut_outs() !== '0) begin
            n_err++;
            $display("[TB] FAIL reset.outputs got=%h exp=%h", dut_outs(), {OW{1'b0}});
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        n_vec++;
        if (dut_outs() !== exp_outs()) begin
            n_err++;
            $display("[TB] FAIL reset.idle got=%h exp=%h", dut_outs(), exp_outs());
        end
    endtask

    task automatic test_single_grant();
        drive(3'b100, '0, '0);
        step();
        n_vec++;
        if (bus.gnt !== 3'b100 || dut_outs() !== exp_outs()) begin
            n_err++;
            $display("[TB] FAIL single.gnt got=%h exp=%h", dut_outs(), exp_outs());
        end
        drive(3'b100, 3'b100, 3'b100);
        bus.x_in[2*X_W +: X_W]       = X_W'(10);
        bus.y_in[2*Y_W +: Y_W]       = Y_W'(20);
        bus.col_in[2*COL_W +: COL_W] = 6'h3F;
        step();
        n_vec++;
        if (bus.plot_out !== 1'b1 || bus.x_out !== X_W'(10) || bus.y_out !== Y_W'(20) ||
            bus.col_out !== 6'h3F || bus.gnt !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL single.pixel got plot=%b x=%0d y=%0d col=%h gnt=%b exp plot=1 x=10 y=20 col=3f gnt=000",
                     bus.plot_out, bus.x_out, bus.y_out, bus.col_out, bus.gnt);
        end
        n_vec++;
        if (dut_outs() !== exp_outs()) begin
            n_err++;
            $display("[TB] FAIL single.model got=%h exp=%h", dut_outs(), exp_outs());
        end
        drive('0, '0, '0);
        step();
        n_vec++;
        if (bus.plot_out !== 1'b0 || bus.gnt !== 3'b000 || bus.x_out !== X_W'(10)) begin
            n_err++;
            $display("[TB] FAIL single.after got plot=%b gnt=%b x=%0d exp plot=0 gnt=000 x=10",
                     bus.plot_out, bus.gnt, bus.x_out);
        end
    endtask

    task automatic test_priority();
        logic [N-1:0] reqs [5]  = '{3'b111, 3'b111, 3'b110, 3'b110, 3'b110};
        logic [N-1:0] plots [5] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000};
        logic [N-1:0] gnts [5]  = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
        for (int i = 0; i < 5; i++) begin
            drive(reqs[i], plots[i], plots[i]);
            step();
            n_vec++;
            if (bus.gnt !== gnts[i] || dut_outs() !== exp_outs()) begin
                n_err++;
                $display("[TB] FAIL priority.step%0d gnt=%b exp_gnt=%b outs=%h exp=%h",
                         i, bus.gnt, gnts[i], dut_outs(), exp_outs());
            end
        end
        quiesce();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] seen [$];
        logic [N-1:0] want [5] = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b100};
        logic [N-1:0] prev, p;
        logic         r0;
        prev = '0;
        for (int i = 0; i < 10; i++) begin
            r0 = (i >= 5 && i <= 7);
            p  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            drive({2'b11, r0}, p, p);
            step();
            n_vec++;
            if (dut_outs() !== exp_outs()) begin
                n_err++;
                $display("[TB] FAIL rr.model cycle%0d got=%h exp=%h", i, dut_outs(), exp_outs());
            end
            if (prev == '0 && bus.gnt != '0) seen.push_back(bus.gnt);
            prev = bus.gnt;
        end
        n_vec++;
        if (seen.size() < 5) begin
            n_err++;
            $display("[TB] FAIL rr.count got=%0d grants exp=5", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (seen[i] !== want[i]) begin
                    n_err++;
                    $display("[TB] FAIL rr.order grant%0d got=%b exp=%b", i, seen[i], want[i]);
                end
            end
        end
        quiesce();
    endtask

    task automatic test_burst_timeout();
        int pulses;
        pulses = 0;
        drive(3'b100, '0, '0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(3'b110, 3'b100, '0);
            step();
            pulses += int'(bus.plot_out);
            n_vec++;
            if (dut_outs() !== exp_outs()) begin
                n_err++;
                $display("[TB] FAIL burst.model pix%0d got=%h exp=%h", i, dut_outs(), exp_outs());
            end
        end
        n_vec++;
        if (pulses !== 4 || bus.gnt !== 3'b000) begin
            n_err++;
            $display("[TB] FAIL burst.cut got pulses=%0d gnt=%b exp pulses=4 gnt=000", pulses, bus.gnt);
        end
        drive(3'b110, '0, '0);
        step();
        n_vec++;
        if (bus.gnt !== 3'b010) begin
            n_err++;
            $display("[TB] FAIL burst.next got=%b exp=010", bus.gnt);
        end
        quiesce();
    endtask

    task automatic test_no_contention();
        int pulses;
        pulses = 0;
        drive(3'b100, '0, '0);
        step();
        for (int i = 0; i < 100; i++) begin
            drive(3'b100, 3'b100, '0);
            step();
            pulses += int'(bus.plot_out);
            n_vec++;
            if (dut_outs() !== exp_outs()) begin
                n_err++;
                $display("[TB] FAIL nocont.model pix%0d got=%h exp=%h", i, dut_outs(), exp_outs());
            end
        end
        n_vec++;
        if (pulses !== 100 || bus.gnt !== 3'b100) begin
            n_err++;
            $display("[TB] FAIL nocont.held got pulses=%0d gnt=%b exp pulses=100 gnt=100", pulses, bus.gnt);
        end
        drive(3'b100, 3'b100, 3'b100);
        step();
        quiesce();
    endtask

    task automatic test_drop_reset();
        drive(3'b010, '0, '0);
        step();
        drive(3'b010, 3'b110, '0);
        step();
        n_vec++;
        if (bus.dropped !== 1'b1 || bus.plot_out !== 1'b1 || dut_outs() !== exp_outs()) begin
            n_err++;
            $display("[TB] FAIL drop.pulse got=%h exp=%h", dut_outs(), exp_outs());
        end
        drive(3'b010, '0, '0);
        step();
        n_vec++;
        if (bus.dropped !== 1'b0 || bus.plot_out !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL drop.clear got dropped=%b plot=%b exp 0 0", bus.dropped, bus.plot_out);
        end
        drive(3'b010, 3'b010, '0);
        #3 reset = 1'b0;
        #1;
        n_vec++;
        if (dut_outs() !== '0) begin
            n_err++;
            $display("[TB] FAIL drop.async_reset got=%h exp=%h", dut_outs(), {OW{1'b0}});
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(3'b110, '0, '0);
        step();
        n_vec++;
        if (bus.gnt !== 3'b010 || dut_outs() !== exp_outs()) begin
            n_err++;
            $display("[TB] FAIL drop.ptr_after_reset got gnt=%b exp=010", bus.gnt);
        end
        quiesce();
    endtask

    task automatic test_random();
        logic [N-1:0] r, p, l;
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 5) == 0) r[k] = ~r[k];
                p[k] = ($urandom_range(0, 1) == 1);
                l[k] = ($urandom_range(0, 7) == 0);
            end
            drive(r, p, l);
            step();
            n_vec++;
            if (dut_outs() !== exp_outs()) begin
                n_err++;
                $display("[TB] FAIL random cycle%0d got=%h exp=%h", i, dut_outs(), exp_outs());
            end
        end
        quiesce();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_grant();
        test_priority();
        test_round_robin();
        test_burst_timeout();
        test_no_contention();
        test_drop_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
